// File: rtl/magic_device_arbiter_pkg.sv
// Shared widths, FSM state encoding and the timeout fill word for magic_device_arbiter.
package magic_arb_pkg;
  localparam int SELECT_W = 12;
  localparam int DATA_W   = 64;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arb_state_e;
endpackage

// File: rtl/magic_device_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr, wrapping, wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any
);
  // Outer loop walks priority order from ptr; inner loop maps that slot to a constant index.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
          any       = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = PTR_W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/magic_device_arbiter.sv
// Round-robin sharing of the one-outstanding-read MagicDeviceBlackbox channel among NUM_REQ requesters.
// Define MAGIC_ARB_TIMEOUT_EN to build the WAIT watchdog that answers with TIMEOUT_DATA and resp_err.
module magic_device_arbiter
  import magic_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*SELECT_W-1:0]  req_select,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [DATA_W-1:0]            resp_data,
  output logic                         resp_err,
  output logic                         busy,
  output logic [SELECT_W-1:0]          read_select,
  output logic                         read_ready,
  input  logic                         read_valid,
  input  logic [DATA_W-1:0]            read_data
);
  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e          state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    gid;
  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                any;
  logic [SELECT_W-1:0] sel_pick;
  logic [NUM_REQ-1:0]  gid_onehot;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Masked during reset so no requester believes it was accepted by a transaction that never starts.
  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    sel_pick = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) sel_pick = req_select[i*SELECT_W +: SELECT_W];
  end

  always_comb begin
    gid_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++)
      gid_onehot[i] = (gid == PTR_W'(i));
  end

`ifdef MAGIC_ARB_TIMEOUT_EN
  logic [31:0] wdog;
  logic        wdog_hit;
  assign wdog_hit = (wdog == 32'(TIMEOUT_CYCLES - 1));
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      gid         <= '0;
      read_select <= '0;
      read_ready  <= 1'b0;
      resp_valid  <= '0;
      resp_data   <= '0;
`ifdef MAGIC_ARB_TIMEOUT_EN
      resp_err    <= 1'b0;
      wdog        <= '0;
`endif
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            read_select <= sel_pick;
            gid         <= grant_idx;
            read_ready  <= 1'b1;
            state       <= WAIT;
`ifdef MAGIC_ARB_TIMEOUT_EN
            wdog        <= '0;
`endif
          end
        end
        WAIT: begin
          // Device data takes priority over a watchdog expiry in the same cycle.
          if (read_valid) begin
            resp_data  <= read_data;
            read_ready <= 1'b0;
            resp_valid <= gid_onehot;
            state      <= RESP;
`ifdef MAGIC_ARB_TIMEOUT_EN
            resp_err   <= 1'b0;
          end else if (wdog_hit) begin
            resp_data  <= TIMEOUT_DATA;
            resp_err   <= 1'b1;
            read_ready <= 1'b0;
            resp_valid <= gid_onehot;
            state      <= RESP;
          end else begin
            wdog       <= wdog + 32'd1;
`endif
          end
        end
        RESP: begin
          ptr   <= (gid == PTR_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_magic_device_arbiter.sv
// Directed scoreboard bench for magic_device_arbiter: a driver pushes expected responses, a monitor pops them.
module tb_magic_device_arbiter;
  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N*12-1:0] req_select;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [63:0]     resp_data;
  logic            resp_err;
  logic            busy;
  logic [11:0]     read_select;
  logic            read_ready;
  logic            read_valid;
  logic [63:0]     read_data;

  always #5 clock = ~clock;

  magic_device_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_select  (req_select),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .busy        (busy),
    .read_select (read_select),
    .read_ready  (read_ready),
    .read_valid  (read_valid),
    .read_data   (read_data)
  );

  typedef struct {
    int          idx;
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [11:0] sel_tab [N][4];
  logic [63:0] dat_tab [N][4];
  int          pos [N];
  int          num [N];
  int          dev_delay = 0;
  bit          dev_mute = 1'b0;
  bit          dev_fixed_en = 1'b0;
  logic [63:0] dev_fixed = 64'h0;
  logic [11:0] exp_sel = 12'h0;
  logic [31:0] order = 32'h0;
  logic [N-1:0] hs;
  logic [3:0]  mon_oh;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++)
      if (pos[i] < num[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      pos[i] = 0;
      num[i] = 0;
    end
    order = 32'h0;
  endtask

  task automatic load(input int i, input logic [11:0] s, input logic [63:0] d);
    sel_tab[i][num[i]] = s;
    dat_tab[i][num[i]] = d;
    num[i]++;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (n < 2000 && !(all_done() && !busy && sb.size() == 0)) begin
      @(posedge clock); #3;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", nm, n);
    end
    @(posedge clock); #3;
  endtask

  // Device model: answers dev_delay cycles after read_ready rises with a select-derived word.
  initial begin
    int dcnt = 0;
    read_valid = 1'b0;
    read_data  = 64'h0;
    forever begin
      @(posedge clock); #1;
      if (read_ready && !dev_mute) begin
        if (dcnt == dev_delay) begin
          read_valid = 1'b1;
          read_data  = dev_fixed_en ? dev_fixed : {52'hFACE000000000, read_select};
          dcnt = 0;
        end else begin
          read_valid = 1'b0;
          dcnt++;
        end
      end else begin
        read_valid = 1'b0;
        dcnt = 0;
      end
    end
  end

  // Requester driver: holds each requester's current select until accepted, records grants.
  initial begin
    req_valid  = '0;
    req_select = '0;
    hs         = '0;
    for (int i = 0; i < N; i++) begin
      pos[i] = 0;
      num[i] = 0;
    end
    forever begin
      @(negedge clock);
      if (read_ready) chk("read_select_stable", 64'(read_select), 64'(exp_sel));
      hs = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          order   = (order << 4) | 32'(i);
          exp_sel = sel_tab[i][pos[i]];
          if (dev_mute) begin
`ifdef MAGIC_ARB_TIMEOUT_EN
            sb.push_back('{i, 64'hDEADBEEFDEADBEEF, 1'b1, cyc + 17});
`endif
          end else begin
            sb.push_back('{i, dat_tab[i][pos[i]], 1'b0, cyc + 2 + dev_delay});
          end
        end
      end
      @(posedge clock); #2;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) pos[i]++;
        req_valid[i] = (pos[i] < num[i]);
        req_select[i*12 +: 12] = (pos[i] < num[i]) ? sel_tab[i][pos[i]] : 12'h0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever any response strobe is seen.
  initial begin
    forever begin
      @(negedge clock);
      if (busy) chk("req_ready_while_busy", 64'(req_ready), 64'h0);
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected: got resp_valid %b expected none", resp_valid);
        end else begin
          mon_e  = sb.pop_front();
          mon_oh = 4'b0001 << mon_e.idx;
          chk("resp_valid", 64'(resp_valid), 64'(mon_oh));
          chk("resp_data", resp_data, mon_e.data);
          chk("resp_err", 64'(resp_err), 64'(mon_e.err));
          chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp_data", resp_data, 64'h0);
    chk("rst_resp_err", 64'(resp_err), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_read_ready", 64'(read_ready), 64'h0);
    chk("rst_read_select", 64'(read_select), 64'h0);
    @(posedge clock); #3;

    // Single request, immediate device
    clr();
    dev_fixed_en = 1'b1;
    dev_fixed    = 64'h1234;
    load(1, 12'h0A5, 64'h1234);
    @(posedge clock); #3;
    @(negedge clock);
    chk("t1_req_ready", 64'(req_ready), 64'h2);
    @(negedge clock);
    chk("t1_read_select", 64'(read_select), 64'h0A5);
    chk("t1_read_ready", 64'(read_ready), 64'h1);
    @(posedge clock); #3;
    wait_idle("t1");
    dev_fixed_en = 1'b0;

    // Requester 3 alone: pointer wraps back to 0
    clr();
    load(3, 12'h333, 64'hFACE000000000333);
    wait_idle("wrap");

    // All four requesting continuously
    clr();
    load(0, 12'h100, 64'hFACE000000000100); load(0, 12'h101, 64'hFACE000000000101);
    load(1, 12'h110, 64'hFACE000000000110); load(1, 12'h111, 64'hFACE000000000111);
    load(2, 12'h120, 64'hFACE000000000120); load(2, 12'h121, 64'hFACE000000000121);
    load(3, 12'h130, 64'hFACE000000000130); load(3, 12'h131, 64'hFACE000000000131);
    wait_idle("t2");
    chk("t2_grant_order", 64'(order), 64'h01230123);

    // Slow device with a competing requester
    clr();
    dev_delay = 50;
    load(0, 12'h00F, 64'hFACE00000000000F);
    load(2, 12'h2C2, 64'hFACE0000000002C2);
    wait_idle("t3");
    chk("t3_grant_order", 64'(order), 64'h02);
    dev_delay = 0;

`ifdef MAGIC_ARB_TIMEOUT_EN
    // Watchdog expiry, then normal service
    clr();
    dev_mute = 1'b1;
    load(1, 12'h0F1, 64'h0);
    wait_idle("t4_timeout");
    dev_mute = 1'b0;
    clr();
    load(2, 12'h222, 64'hFACE000000000222);
    wait_idle("t4_after");
    // Device answers on the watchdog limit cycle
    clr();
    dev_delay = 15;
    load(3, 12'h3A3, 64'hFACE0000000003A3);
    wait_idle("t5_tie");
    dev_delay = 0;
`endif

    // Reset while a read is outstanding, pointer left at 2
    clr();
    load(1, 12'h1B1, 64'hFACE0000000001B1);
    wait_idle("t6_pre");
    clr();
    dev_mute = 1'b1;
    load(1, 12'h1F1, 64'h0);
    repeat (4) begin @(posedge clock); #3; end
    chk("t6_busy_before", 64'(busy), 64'h1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("t6_read_ready", 64'(read_ready), 64'h0);
    chk("t6_busy", 64'(busy), 64'h0);
    chk("t6_resp_valid", 64'(resp_valid), 64'h0);
    chk("t6_resp_data", resp_data, 64'h0);
    chk("t6_read_select", 64'(read_select), 64'h0);
    sb.delete();
    dev_mute = 1'b0;
    #2;
    clr();
    load(0, 12'h0E0, 64'hFACE0000000000E0);
    load(2, 12'h2E2, 64'hFACE0000000002E2);
    wait_idle("t6_after");
    chk("t6_grant_order", 64'(order), 64'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
